// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: store lane formatting, req/ready data-memory handshake,
// load extraction and MEM/WB registers. Define MEM_TIMEOUT_EN for the TIMEOUT-cycle bus watchdog.
module mem_stage_lsu #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_valid,
  input  logic              flush,
  input  logic [31:0]       i_ALU_out,
  input  logic [31:0]       i_Store_Data,
  input  logic [4:0]        i_rd,
  input  logic [31:0]       i_PC_plus_4,
  input  logic              i_RegWrite,
  input  logic              i_MemWrite,
  input  logic              i_MemRead,
  input  logic [1:0]        i_WDSel,
  input  logic [2:0]        i_DMType,
  output logic              stall_o,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_ready,
  input  logic [31:0]       dmem_rdata,
  output logic              o_valid,
  output logic              o_RegWrite,
  output logic [4:0]        o_rd,
  output logic [1:0]        o_WDSel,
  output logic [31:0]       o_ALU_out,
  output logic [31:0]       o_Load_Data,
  output logic [31:0]       o_PC_plus_4,
  output logic              o_misaligned,
  output logic              o_bus_err
);

  typedef enum logic {IDLE, BUSY} state_e;
  state_e state_q;

  logic        mem_op, is_word, is_half, misaligned, mis_op, issue;
  logic        retire, discard, timeout_hit;
  logic [31:0] wdata_d, lane_sh, load_d;
  logic [3:0]  be_d;

  // Entry captured at issue so a flush that clears EX/MEM cannot corrupt the retire.
  logic [4:0]  pend_rd_q;
  logic        pend_rw_q, pend_store_q, flush_pend_q;
  logic [1:0]  pend_wdsel_q;
  logic [31:0] pend_alu_q, pend_pc4_q;
  logic [2:0]  pend_dmtype_q;

  assign mem_op     = i_valid & (i_MemRead | i_MemWrite);
  assign is_word    = (i_DMType == 3'b000);
  assign is_half    = (i_DMType == 3'b001) | (i_DMType == 3'b010);
  assign misaligned = (is_word & (i_ALU_out[1:0] != 2'b00)) | (is_half & i_ALU_out[0]);
  assign mis_op     = mem_op & misaligned;
  assign issue      = mem_op & ~misaligned & ~flush;

  assign retire  = (state_q == BUSY) & (dmem_ready | timeout_hit);
  assign discard = flush_pend_q | flush;
  assign stall_o = (state_q == IDLE) ? issue : ~retire;

  always_comb begin
    wdata_d = i_Store_Data;
    be_d    = 4'b1111;
    case (i_DMType)
      3'b011, 3'b100: begin
        wdata_d = {4{i_Store_Data[7:0]}};
        be_d    = 4'b0001 << i_ALU_out[1:0];
      end
      3'b001, 3'b010: begin
        wdata_d = {2{i_Store_Data[15:0]}};
        be_d    = i_ALU_out[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  assign lane_sh = dmem_rdata >> {pend_alu_q[1:0], 3'b000};

  always_comb begin
    load_d = lane_sh;
    case (pend_dmtype_q)
      3'b001:  load_d = {{16{lane_sh[15]}}, lane_sh[15:0]};
      3'b010:  load_d = {16'h0000, lane_sh[15:0]};
      3'b011:  load_d = {{24{lane_sh[7]}}, lane_sh[7:0]};
      3'b100:  load_d = {24'h000000, lane_sh[7:0]};
      default: ;
    endcase
    if (pend_store_q) load_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_wdata    <= '0;
      dmem_be       <= '0;
      o_valid       <= 1'b0;
      o_RegWrite    <= 1'b0;
      o_rd          <= '0;
      o_WDSel       <= '0;
      o_ALU_out     <= '0;
      o_Load_Data   <= '0;
      o_PC_plus_4   <= '0;
      o_misaligned  <= 1'b0;
      pend_rd_q     <= '0;
      pend_rw_q     <= 1'b0;
      pend_store_q  <= 1'b0;
      pend_wdsel_q  <= '0;
      pend_alu_q    <= '0;
      pend_pc4_q    <= '0;
      pend_dmtype_q <= '0;
      flush_pend_q  <= 1'b0;
    end else begin
      o_valid      <= 1'b0;
      o_RegWrite   <= 1'b0;
      o_misaligned <= 1'b0;
      if (state_q == IDLE) begin
        if (issue) begin
          state_q       <= BUSY;
          dmem_req      <= 1'b1;
          dmem_we       <= i_MemWrite;
          dmem_addr     <= {i_ALU_out[ADDR_W-1:2], 2'b00};
          dmem_wdata    <= wdata_d;
          dmem_be       <= be_d;
          pend_rd_q     <= i_rd;
          pend_rw_q     <= i_RegWrite;
          pend_store_q  <= i_MemWrite;
          pend_wdsel_q  <= i_WDSel;
          pend_alu_q    <= i_ALU_out;
          pend_pc4_q    <= i_PC_plus_4;
          pend_dmtype_q <= i_DMType;
          flush_pend_q  <= 1'b0;
        end else begin
          o_valid      <= i_valid & ~flush;
          o_RegWrite   <= i_valid & ~flush & i_RegWrite & ~mis_op;
          o_misaligned <= ~flush & mis_op;
          o_rd         <= i_rd;
          o_WDSel      <= i_WDSel;
          o_ALU_out    <= i_ALU_out;
          o_PC_plus_4  <= i_PC_plus_4;
          o_Load_Data  <= '0;
        end
      end else if (retire) begin
        state_q     <= IDLE;
        dmem_req    <= 1'b0;
        dmem_we     <= 1'b0;
        o_valid     <= ~discard;
        o_RegWrite  <= ~discard & ~timeout_hit & pend_rw_q;
        o_rd        <= pend_rd_q;
        o_WDSel     <= pend_wdsel_q;
        o_ALU_out   <= pend_alu_q;
        o_PC_plus_4 <= pend_pc4_q;
        o_Load_Data <= timeout_hit ? 32'h0 : load_d;
      end else if (flush) begin
        flush_pend_q <= 1'b1;
      end
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] cnt_q;
  logic             bus_err_q;

  // Fires in the BUSY cycle whose edge would bring the count up to TIMEOUT.
  assign timeout_hit = (state_q == BUSY) & ~dmem_ready & (cnt_q == CNT_W'(TIMEOUT - 1));
  assign o_bus_err   = bus_err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= timeout_hit & ~discard;
      if (state_q == IDLE) cnt_q <= '0;
      else if (!dmem_ready) cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  // Watchdog compiled out: BUSY waits for dmem_ready indefinitely.
  assign timeout_hit = 1'b0 & (TIMEOUT > 0);
  assign o_bus_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu (ALU pass-through, loads, stores,
// misalignment, flush in IDLE/BUSY, async reset, and the MEM_TIMEOUT_EN watchdog when defined).
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_valid, flush;
  logic [31:0] i_ALU_out, i_Store_Data, i_PC_plus_4;
  logic [4:0]  i_rd;
  logic        i_RegWrite, i_MemWrite, i_MemRead;
  logic [1:0]  i_WDSel;
  logic [2:0]  i_DMType;
  logic        stall_o, dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        o_valid, o_RegWrite, o_misaligned, o_bus_err;
  logic [4:0]  o_rd;
  logic [1:0]  o_WDSel;
  logic [31:0] o_ALU_out, o_Load_Data, o_PC_plus_4;

  int compared   = 0;
  int mismatched = 0;

  mem_stage_lsu #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n), .i_valid(i_valid), .flush(flush),
    .i_ALU_out(i_ALU_out), .i_Store_Data(i_Store_Data), .i_rd(i_rd),
    .i_PC_plus_4(i_PC_plus_4), .i_RegWrite(i_RegWrite), .i_MemWrite(i_MemWrite),
    .i_MemRead(i_MemRead), .i_WDSel(i_WDSel), .i_DMType(i_DMType),
    .stall_o(stall_o), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .o_valid(o_valid), .o_RegWrite(o_RegWrite), .o_rd(o_rd), .o_WDSel(o_WDSel),
    .o_ALU_out(o_ALU_out), .o_Load_Data(o_Load_Data), .o_PC_plus_4(o_PC_plus_4),
    .o_misaligned(o_misaligned), .o_bus_err(o_bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_valid = 1'b0; flush = 1'b0; i_ALU_out = '0; i_Store_Data = '0; i_rd = '0;
    i_PC_plus_4 = '0; i_RegWrite = 1'b0; i_MemWrite = 1'b0; i_MemRead = 1'b0;
    i_WDSel = '0; i_DMType = '0;
  endtask

  task automatic set_mem(input logic we, input logic [2:0] dmt, input logic [31:0] addr,
                         input logic [31:0] sdata);
    i_valid = 1'b1; flush = 1'b0; i_MemWrite = we; i_MemRead = ~we; i_RegWrite = ~we;
    i_DMType = dmt; i_ALU_out = addr; i_Store_Data = sdata; i_rd = 5'd9;
    i_WDSel = 2'd2; i_PC_plus_4 = 32'h0000_1000;
  endtask

  // One complete access: issue, `waits` cycles without ready, then a ready cycle.
  task automatic mem_access(input string tag, input logic we, input logic [2:0] dmt,
                            input logic [31:0] addr, input logic [31:0] sdata,
                            input logic [31:0] rdata, input int waits,
                            input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                            input logic [31:0] exp_load);
    int stalls;
    stalls = 0;
    set_mem(we, dmt, addr, sdata);
    #1;
    if (stall_o) stalls++;
    tick();
    for (int i = 0; i <= waits; i++) begin
      if (i == waits) begin
        dmem_ready = 1'b1;
        dmem_rdata = rdata;
      end
      #1;
      chk({tag, " req"}, {31'b0, dmem_req}, 32'd1);
      chk({tag, " addr"}, dmem_addr, {addr[31:2], 2'b00});
      chk({tag, " we"}, {31'b0, dmem_we}, {31'b0, we});
      if (we) begin
        chk({tag, " be"}, {28'b0, dmem_be}, {28'b0, exp_be});
        chk({tag, " wdata"}, dmem_wdata, exp_wdata);
      end
      if (i == 0) chk({tag, " bubble"}, {31'b0, o_valid}, 32'd0);
      if (stall_o) stalls++;
      tick();
    end
    dmem_ready = 1'b0;
    dmem_rdata = 32'hDEAD_DEAD;
    idle_inputs();
    #1;
    chk({tag, " stall_cycles"}, 32'(stalls), 32'(waits + 1));
    chk({tag, " o_valid"}, {31'b0, o_valid}, 32'd1);
    chk({tag, " load"}, o_Load_Data, exp_load);
    chk({tag, " o_RegWrite"}, {31'b0, o_RegWrite}, {31'b0, ~we});
    chk({tag, " o_rd"}, {27'b0, o_rd}, 32'd9);
    chk({tag, " o_ALU_out"}, o_ALU_out, addr);
    chk({tag, " req_drop"}, {31'b0, dmem_req}, 32'd0);
    chk({tag, " stall_after"}, {31'b0, stall_o}, 32'd0);
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    reset_n = 1'b0; dmem_ready = 1'b0; dmem_rdata = '0;
    idle_inputs();
    tick(); tick();
    chk("rst o_valid", {31'b0, o_valid}, 32'd0);
    chk("rst dmem_req", {31'b0, dmem_req}, 32'd0);
    chk("rst dmem_be", {28'b0, dmem_be}, 32'd0);
    chk("rst o_ALU_out", o_ALU_out, 32'd0);
    chk("rst stall", {31'b0, stall_o}, 32'd0);
    chk("rst bus_err", {31'b0, o_bus_err}, 32'd0);
    reset_n = 1'b1;
    tick();

    // ALU pass-through: 1-cycle latency, no stall, no bus traffic
    i_valid = 1'b1; i_ALU_out = 32'h0000_1234; i_rd = 5'd5; i_RegWrite = 1'b1;
    i_WDSel = 2'd1; i_PC_plus_4 = 32'h0000_0044;
    #1;
    chk("alu stall", {31'b0, stall_o}, 32'd0);
    tick();
    idle_inputs();
    #1;
    chk("alu o_valid", {31'b0, o_valid}, 32'd1);
    chk("alu o_ALU_out", o_ALU_out, 32'h0000_1234);
    chk("alu o_rd", {27'b0, o_rd}, 32'd5);
    chk("alu o_RegWrite", {31'b0, o_RegWrite}, 32'd1);
    chk("alu o_WDSel", {30'b0, o_WDSel}, 32'd1);
    chk("alu o_PC_plus_4", o_PC_plus_4, 32'h0000_0044);
    chk("alu dmem_req", {31'b0, dmem_req}, 32'd0);
    chk("alu stall2", {31'b0, stall_o}, 32'd0);
    tick();
    chk("bubble o_valid", {31'b0, o_valid}, 32'd0);
    chk("bubble o_RegWrite", {31'b0, o_RegWrite}, 32'd0);

    // Loads and stores
    mem_access("lb",   1'b0, 3'b011, 32'h0000_0103, 32'h0, 32'h80FF_1122, 0, 4'h0, 32'h0, 32'hFFFF_FF80);
    mem_access("lbu",  1'b0, 3'b100, 32'h0000_0101, 32'h0, 32'h80FF_1122, 1, 4'h0, 32'h0, 32'h0000_0011);
    mem_access("lh",   1'b0, 3'b001, 32'h0000_0002, 32'h0, 32'h80FF_1122, 0, 4'h0, 32'h0, 32'hFFFF_80FF);
    mem_access("lhu",  1'b0, 3'b010, 32'h0000_0002, 32'h0, 32'h80FF_1122, 2, 4'h0, 32'h0, 32'h0000_80FF);
    mem_access("lh0",  1'b0, 3'b001, 32'h0000_0000, 32'h0, 32'h1234_8001, 0, 4'h0, 32'h0, 32'hFFFF_8001);
    mem_access("lw",   1'b0, 3'b000, 32'h0000_0000, 32'h0, 32'h80FF_1122, 0, 4'h0, 32'h0, 32'h80FF_1122);
    mem_access("sb1",  1'b1, 3'b011, 32'h0000_0201, 32'h1234_56A5, 32'h0, 0, 4'b0010, 32'hA5A5_A5A5, 32'h0);
    mem_access("sb3",  1'b1, 3'b011, 32'h0000_0203, 32'h0000_007F, 32'h0, 1, 4'b1000, 32'h7F7F_7F7F, 32'h0);
    mem_access("sh2",  1'b1, 3'b001, 32'h0000_0202, 32'hABCD_5678, 32'h0, 3, 4'b1100, 32'h5678_5678, 32'h0);
    mem_access("sh0",  1'b1, 3'b001, 32'h0000_0200, 32'h0000_BEEF, 32'h0, 0, 4'b0011, 32'hBEEF_BEEF, 32'h0);
    mem_access("sw",   1'b1, 3'b000, 32'h0000_0204, 32'hDEAD_BEEF, 32'h0, 1, 4'b1111, 32'hDEAD_BEEF, 32'h0);

    // Misaligned word and half loads retire in one cycle with no request
    set_mem(1'b0, 3'b000, 32'h0000_0101, 32'h0);
    #1;
    chk("mis_lw stall", {31'b0, stall_o}, 32'd0);
    tick();
    idle_inputs();
    #1;
    chk("mis_lw req", {31'b0, dmem_req}, 32'd0);
    chk("mis_lw o_valid", {31'b0, o_valid}, 32'd1);
    chk("mis_lw o_misaligned", {31'b0, o_misaligned}, 32'd1);
    chk("mis_lw o_RegWrite", {31'b0, o_RegWrite}, 32'd0);
    set_mem(1'b0, 3'b001, 32'h0000_0001, 32'h0);
    tick();
    idle_inputs();
    #1;
    chk("mis_lh req", {31'b0, dmem_req}, 32'd0);
    chk("mis_lh o_misaligned", {31'b0, o_misaligned}, 32'd1);
    chk("mis_lh o_RegWrite", {31'b0, o_RegWrite}, 32'd0);
    tick();
    chk("mis clear", {31'b0, o_misaligned}, 32'd0);

    // Flush in IDLE: aligned load is dropped without a request
    set_mem(1'b0, 3'b000, 32'h0000_0010, 32'h0);
    flush = 1'b1;
    #1;
    chk("flush_idle stall", {31'b0, stall_o}, 32'd0);
    tick();
    idle_inputs();
    #1;
    chk("flush_idle req", {31'b0, dmem_req}, 32'd0);
    chk("flush_idle o_valid", {31'b0, o_valid}, 32'd0);
    tick();

    // Flush one cycle into BUSY: handshake completes, result discarded
    set_mem(1'b0, 3'b010, 32'h0000_0000, 32'h0);
    tick();
    flush = 1'b1;
    #1;
    chk("flush_busy req", {31'b0, dmem_req}, 32'd1);
    tick();
    flush = 1'b0;
    #1;
    chk("flush_busy held", {31'b0, dmem_req}, 32'd1);
    chk("flush_busy stall", {31'b0, stall_o}, 32'd1);
    tick();
    dmem_ready = 1'b1; dmem_rdata = 32'h0000_7777;
    #1;
    chk("flush_busy ready_stall", {31'b0, stall_o}, 32'd0);
    tick();
    dmem_ready = 1'b0;
    idle_inputs();
    #1;
    chk("flush_busy o_valid", {31'b0, o_valid}, 32'd0);
    chk("flush_busy o_RegWrite", {31'b0, o_RegWrite}, 32'd0);
    chk("flush_busy req_drop", {31'b0, dmem_req}, 32'd0);
    tick();

    // Ready and flush in the same cycle
    set_mem(1'b0, 3'b000, 32'h0000_0020, 32'h0);
    tick();
    dmem_ready = 1'b1; dmem_rdata = 32'h1111_2222; flush = 1'b1;
    tick();
    dmem_ready = 1'b0;
    idle_inputs();
    #1;
    chk("ready_flush o_valid", {31'b0, o_valid}, 32'd0);
    chk("ready_flush req", {31'b0, dmem_req}, 32'd0);
    tick();

`ifdef MEM_TIMEOUT_EN
    begin
      int busy_cycles;
      busy_cycles = 0;
      set_mem(1'b0, 3'b000, 32'h0000_0040, 32'h0);
      tick();
      for (int i = 0; i < 20 && dmem_req; i++) begin
        busy_cycles++;
        tick();
      end
      idle_inputs();
      #1;
      chk("timeout busy_cycles", 32'(busy_cycles), 32'd4);
      chk("timeout req", {31'b0, dmem_req}, 32'd0);
      chk("timeout o_valid", {31'b0, o_valid}, 32'd1);
      chk("timeout o_bus_err", {31'b0, o_bus_err}, 32'd1);
      chk("timeout o_RegWrite", {31'b0, o_RegWrite}, 32'd0);
      tick();
      chk("timeout err_clear", {31'b0, o_bus_err}, 32'd0);
    end
`else
    // Without the watchdog a long wait still completes normally
    mem_access("lw_wait8", 1'b0, 3'b000, 32'h0000_0008, 32'h0, 32'h0102_0304, 8, 4'h0, 32'h0, 32'h0102_0304);
    chk("no_wdog bus_err", {31'b0, o_bus_err}, 32'd0);
`endif

    // Asynchronous reset mid-access drops the request without a clock edge
    set_mem(1'b0, 3'b000, 32'h0000_0030, 32'h0);
    tick();
    chk("arst req_before", {31'b0, dmem_req}, 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst req", {31'b0, dmem_req}, 32'd0);
    chk("arst o_valid", {31'b0, o_valid}, 32'd0);
    idle_inputs();
    reset_n = 1'b1;
    tick();
    #1;
    chk("arst idle req", {31'b0, dmem_req}, 32'd0);
    chk("arst idle stall", {31'b0, stall_o}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Consumer end of the EX/MEM pipeline interface: the MEM-stage load/store unit of the 5-stage RV32I core.
- Takes the registered EX/MEM bundle, formats stores into byte lanes, and runs a req/ready handshake to the data memory. It extracts and sign- or zero-extends load data.
- Registers the result into MEM/WB outputs and stalls upstream stages while a memory access is outstanding.

Parameters:
- ADDR_W, 32, data memory byte-address width.
- TIMEOUT, 255, watchdog limit in cycles; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- i_valid  in  1  EX/MEM entry valid.
- flush  in  1  kill the current entry.
- i_ALU_out  in  32  effective address, or ALU result.
- i_Store_Data  in  32  rs2 store data.
- i_rd  in  5  destination register.
- i_PC_plus_4  in  32  link value.
- i_RegWrite, i_MemWrite, i_MemRead  in  1 each  control signals.
- i_WDSel  in  2  WB select.
- i_DMType  in  3  access type: 000 word, 001 half, 010 half unsigned, 011 byte, 100 byte unsigned.
- stall_o  out  1  hold EX/MEM and all earlier stages.
- dmem_req  out  1  bus request.
- dmem_we  out  1  write enable.
- dmem_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00}).
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_ready  in  1  transfer complete this cycle.
- dmem_rdata  in  32  read data, valid when dmem_ready.
- o_valid, o_RegWrite  out  1  MEM/WB valid and write enable.
- o_rd  out  5  MEM/WB destination register.
- o_WDSel  out  2  MEM/WB WB select.
- o_ALU_out, o_Load_Data, o_PC_plus_4  out  32  MEM/WB data.
- o_misaligned  out  1  misaligned access flag, aligned with o_valid.
- o_bus_err  out  1  watchdog abort flag (tied 0 without the macro).

Behaviour:
- Reset: all outputs 0, dmem_* 0, FSM in IDLE, asynchronously while reset_n=0.
- mem_op = i_valid & (i_MemRead | i_MemWrite).
- Misaligned: (word & a[1:0]!=0) | (half & a[0]).
- Non-mem op, or misaligned mem op, in IDLE:
  - Output registers load at the next edge (1-cycle latency); stall_o=0; no bus activity.
  - Misaligned: o_misaligned=1, o_RegWrite=0.
- FSM states: IDLE and BUSY.
- IDLE with an aligned mem_op:
  - stall_o=1 combinationally.
  - Next edge: BUSY, with dmem_req=1 and dmem_we/addr/wdata/be registered.
- BUSY:
  - dmem_* held stable while dmem_ready=0; stall_o = ~dmem_ready.
  - On dmem_ready: the result registers load at that edge, dmem_req falls, state returns to IDLE, and upstream advances on the same edge.
- Zero-wait memory (ready in the first BUSY cycle) gives 2-cycle MEM latency, with 1 bubble.
- Store lanes:
  - Byte: wdata={4{d[7:0]}}, be=4'b0001<<a[1:0].
  - Half: wdata={2{d[15:0]}}, be = a[1] ? 1100 : 0011.
  - Word: be=1111.
- Load: select lane by a[1:0] from rdata; sign-extend for 000/001/011, zero-extend for 010/100. Stores give o_Load_Data=0.
- Output registers: o_rd, o_RegWrite, o_WDSel, o_ALU_out and o_PC_plus_4 copy the inputs on a loading edge. On any non-loading edge, o_valid=0 and o_RegWrite=0 (bubble).
- Flush in IDLE: the next edge loads o_valid=0, o_RegWrite=0, and no request is issued.
- Flush in BUSY: the request is never dropped mid-handshake. It is remembered in a sticky bit, the access completes, and the result is discarded (o_valid=0).
- Simultaneous dmem_ready and flush: discard the result.
- reset_n low mid-access: dmem_req drops immediately and the FSM returns to IDLE. The memory side must tolerate an abandoned request.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - An 8-bit+ counter clears on entering BUSY and increments each BUSY cycle without ready.
  - When it reaches TIMEOUT: dmem_req drops, state returns to IDLE, and the entry retires with o_valid=1, o_bus_err=1, o_RegWrite=0.
- MEM_TIMEOUT_EN undefined: no counter, o_bus_err tied 0, and BUSY waits indefinitely.

Test Plan:
- ALU op, i_ALU_out=0x1234, rd=5, RegWrite=1 -> next cycle o_valid=1, o_ALU_out=0x1234, o_rd=5; stall_o never 1.
- lb at 0x103, rdata=0x80FF_1122, ready immediately -> dmem_addr=0x100, o_Load_Data=0xFFFF_FF80, stall_o high exactly 1 cycle.
- sh at 0x202, data 0xABCD_5678, ready after 3 wait cycles -> dmem_be=1100, dmem_wdata=0x5678_5678, signals stable for 4 cycles, stall_o=1 for 4 cycles.
- lw at 0x101 -> no dmem_req; next cycle o_valid=1, o_misaligned=1, o_RegWrite=0.
- lhu at 0x0, flush asserted 1 cycle into BUSY, ready 2 cycles later -> handshake completes, o_valid stays 0.
- (MEM_TIMEOUT_EN, TIMEOUT=4) lw, ready never asserted -> dmem_req drops after 4 BUSY cycles; o_bus_err=1, o_valid=1, o_RegWrite=0.
